comb_arbiter: RTL and testbench
===============================

# comb_arbiter

Shares one `combinational` 8-bit datapath instance between two requesters. Requests arrive on valid/ready ports and are granted round-robin. The granted operands are registered and held stable for a configurable multicycle evaluation window. The result is then registered and returned on a single response channel tagged with the requester ID. The block sits between requester logic and the datapath and makes the datapath a timed multicycle path with registered inputs and outputs.

## Interface
- `EXEC_CYCLES`, default 1: cycles operands are held before the result is captured; legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 2: per-requester request valid; bit i = requester i.
- `req_ready` out 2: per-requester accept; at most one bit high per cycle.
- `req_x` in 2x8: operand x per requester; `req_x[i]` belongs to requester i.
- `req_y` in 2x8: operand y per requester.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out 8: datapath result.
- `rsp_id` out 1: index of the requester that owns `rsp_data`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `req_ready[g]` = 1 for the granted requester g only.
  - Acceptance occurs when `req_valid[g]` and `req_ready[g]` are both high at a rising edge.
  - On acceptance: capture `req_x[g]` and `req_y[g]` into `x_q`/`y_q`, capture g into `id_q`, load the count with `EXEC_CYCLES-1`, and move to EXEC.
- Grant rule:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one other than `last_q`. `last_q` updates to g on acceptance.
  - If neither is valid, `req_ready` = 0.
- EXEC:
  - `req_ready` = 0.
  - `x_q`/`y_q` drive the datapath and are held constant.
  - The count decrements each cycle. When the count is 0 at an edge, capture the datapath output into `rsp_data` and move to DONE.
- DONE:
  - `rsp_valid` = 1.
  - `rsp_data` and `rsp_id` stay stable until the handshake completes.
  - On `rsp_valid` and `rsp_ready` both high, move to IDLE.
  - `rsp_ready` low stalls indefinitely, with no data loss.
- Requests are never accepted outside IDLE. A requester's `req_valid` held through EXEC/DONE is serviced in a later IDLE according to the grant rule.
- Input operands are sampled only at the accept edge. Changes to them afterwards have no effect.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - State = IDLE, `last_q` = 1, so requester 0 wins the first tie.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0, `x_q`/`y_q` = 0.
- Reset asserted mid-EXEC or mid-DONE:
  - Everything above is forced immediately.
  - The pending result is discarded and no response is issued.
- Latency:
  - Accept edge T.
  - Result captured at edge T+`EXEC_CYCLES`.
  - `rsp_valid` high in the cycle after that edge.
  - With `rsp_ready` held high, the next acceptance can occur at edge T+`EXEC_CYCLES`+2.
  - Throughput: one operation per `EXEC_CYCLES`+2 cycles.
- The datapath is purely combinational. Constrain it as a multicycle path of `EXEC_CYCLES` from `x_q`/`y_q` to `rsp_data`.
- `req_ready` is combinational from state, `req_valid`, and `last_q`. It never depends on `req_x`/`req_y`.
- Other outputs are registered, except `busy`, which decodes from state.

## Structure
- Package `comb_arbiter_pkg`:
  - `DATA_WIDTH = 8`
  - `NUM_REQ = 2`
  - enum `comb_arb_state_t` {IDLE, EXEC, DONE}
  - data and ID typedefs
- The single sub-module is the existing `combinational` datapath. Instantiate it once, with x = `x_q`, y = `y_q`, out → capture mux.
- Keep the round-robin grant as an internal function. No separate module is needed.

## Test plan
- **Single request.** After reset, requester 0 requests x=0xA5, y=0x3C with `EXEC_CYCLES`=1.
  - Expect `req_ready[0]` in the same cycle.
  - Expect `rsp_valid` 2 cycles after the accept, with `rsp_data` = golden `combinational`(0xA5,0x3C) and `rsp_id`=0.
- **Tie after reset.** Both requesters are valid continuously: requester 0 with 0x01/0x02, requester 1 with 0xF0/0x0F.
  - Expect grants alternating 0,1,0,1.
  - Expect `rsp_id` matching the grants, and each `rsp_data` matching its requester's operands.
- **Multicycle window.** Set `EXEC_CYCLES`=4. Change `req_x` right after the accept.
  - Expect `rsp_valid` 5 cycles after the accept.
  - Expect a result computed from the originally captured operands.
- **Response backpressure.** Hold `rsp_ready`=0 for 10 cycles while requester 1 stays valid.
  - Expect `rsp_data`/`rsp_id` stable and `req_ready`=0 throughout.
  - After `rsp_ready` rises, expect the next accept 1 cycle later.
- **Reset mid-EXEC.** Assert `rst_n`=0 during EXEC with `EXEC_CYCLES`=3.
  - Expect all outputs at reset values immediately and no `rsp_valid` afterward.
  - Expect the first post-reset tie to be granted to requester 0.
- **Exhaustive-ish sweep.** 256 random operand pairs across both requesters with random `rsp_ready`.
  - Scoreboard order, ID, and data against the golden model. Expect zero mismatches and no dropped or duplicated responses.

Source files
------------

// File: rtl/comb_arbiter_pkg.sv
// Shared types and constants for the two-requester multicycle datapath arbiter.
package comb_arbiter_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_REQ    = 2;
    localparam int CNT_WIDTH  = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [$clog2(NUM_REQ)-1:0] id_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } comb_arb_state_t;

endpackage

// File: rtl/comb_arbiter_combinational.sv
// Purely combinational 8-bit datapath: sum of operands mixed with a nibble swap.
module combinational
    import comb_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int HALF = DATA_WIDTH / 2;

    // Result: (x + y) XOR {low half of x, high half of y}
    always_comb begin
        out = (x + y) ^ {x[HALF-1:0], y[DATA_WIDTH-1:HALF]};
    end

endmodule

// File: rtl/comb_arbiter.sv
// Round-robin arbiter sharing one combinational datapath between two requesters.
// Operands are registered at accept, held for EXEC_CYCLES, and the result is
// registered and returned with the owning requester's ID.
module comb_arbiter
    import comb_arbiter_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_y,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               rsp_id,
    output logic                               busy
);

    comb_arb_state_t state;
    data_t           x_q;
    data_t           y_q;
    id_t             id_q;
    id_t             last_q;
    cnt_t            cnt_q;
    data_t           dp_out;
    id_t             gnt_id;
    logic            accept;

    // One-hot grant: a lone requester wins; on a tie the one that did not win last.
    function automatic logic [NUM_REQ-1:0] rr_grant(input logic [NUM_REQ-1:0] valid,
                                                    input id_t last);
        logic [NUM_REQ-1:0] gnt;
        gnt = '0;
        case (valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == id_t'(1)) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
        return gnt;
    endfunction

    combinational u_dp (
        .x   (x_q),
        .y   (y_q),
        .out (dp_out)
    );

    // Grant decode: only offered in IDLE, never depends on operand values.
    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            req_ready = rr_grant(req_valid, last_q);
        end
        gnt_id = id_t'(req_ready[1]);
        accept = |(req_valid & req_ready);
    end

    // Control FSM with registered operands, result, and response valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_q    <= id_t'(1);
            x_q       <= '0;
            y_q       <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q    <= req_x[gnt_id];
                        y_q    <= req_y[gnt_id];
                        id_q   <= gnt_id;
                        last_q <= gnt_id;
                        cnt_q  <= cnt_t'(EXEC_CYCLES - 1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        rsp_data  <= dp_out;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner ID is only rewritten at accept, so it is stable throughout DONE.
    always_comb begin
        rsp_id = id_q;
        busy   = (state != IDLE);
    end

endmodule

// File: tb/tb_comb_arbiter.sv
// Self-checking bench for comb_arbiter: three instances with EXEC_CYCLES 1, 4, 3,
// a vector table for grant/latency/data, directed corner sequences, and a
// scoreboarded random sweep.
module tb_comb_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n     [NI];
    logic [1:0]      req_valid [NI];
    logic [1:0]      req_ready [NI];
    logic [1:0][7:0] req_x     [NI];
    logic [1:0][7:0] req_y     [NI];
    logic            rsp_valid [NI];
    logic            rsp_ready [NI];
    logic [7:0]      rsp_data  [NI];
    logic            rsp_id    [NI];
    logic            busy      [NI];

    genvar g;
    for (g = 0; g < NI; g++) begin : g_dut
        localparam int ECG = (g == 0) ? 1 : (g == 1) ? 4 : 3;
        comb_arbiter #(.EXEC_CYCLES(ECG)) dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_x     (req_x[g]),
            .req_y     (req_y[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_id    (rsp_id[g]),
            .busy      (busy[g])
        );
    end

    int checks = 0;
    int errors = 0;

    function automatic int ec_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 3;
    endfunction

    // Golden datapath written arithmetically rather than by bit slicing.
    function automatic logic [7:0] golden(input logic [7:0] a, input logic [7:0] b);
        int s;
        int m;
        s = (int'(a) + int'(b)) % 256;
        m = (int'(a) * 16 + int'(b) / 16) % 256;
        return 8'(s ^ m);
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with inputs driven and the DUT idle; returns idle at posedge+1.
    task automatic run_op(input int k, input logic [1:0] exp_rdy, input logic [7:0] exp_data,
                          input bit scramble);
        #3;
        chk("ready_idle", 32'(req_ready[k]), 32'(exp_rdy));
        cyc();
        chk("busy_exec", 32'(busy[k]), 1);
        chk("ready_exec", 32'(req_ready[k]), 0);
        if (scramble) begin
            req_x[k] = ~req_x[k];
            req_y[k] = req_y[k] ^ 16'h5A5A;
        end
        for (int n = 1; n < ec_of(k); n++) begin
            cyc();
            chk("rsp_early", 32'(rsp_valid[k]), 0);
        end
        cyc();
        chk("rsp_valid", 32'(rsp_valid[k]), 1);
        chk("rsp_data", 32'(rsp_data[k]), 32'(exp_data));
        chk("rsp_id", 32'(rsp_id[k]), 32'(exp_rdy[1]));
        cyc();
        chk("rsp_clear", 32'(rsp_valid[k]), 0);
        chk("busy_idle", 32'(busy[k]), 0);
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [7:0] x0, y0, x1, y1;
        logic [1:0] exp_rdy;
    } vec_t;

    vec_t vecs [6];

    // Scoreboard on instance 0 with an independent grant/idle model.
    logic [8:0] sbq [$];
    bit         sb_en  = 1'b0;
    bit         m_idle = 1'b1;
    logic       m_last = 1'b1;
    int         pushed = 0;
    int         popped = 0;

    always @(negedge clk) begin
        logic [1:0] eg;
        logic [8:0] e;
        if (sb_en) begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    popped++;
                    chk("sb_id", 32'(rsp_id[0]), 32'(e[8]));
                    chk("sb_data", 32'(rsp_data[0]), 32'(e[7:0]));
                end
                m_idle = 1'b1;
            end else if (m_idle) begin
                eg = exp_grant(req_valid[0], m_last);
                chk("sb_ready", 32'(req_ready[0]), 32'(eg));
                if (eg != 2'b00) begin
                    sbq.push_back({eg[1], golden(req_x[0][eg[1]], req_y[0][eg[1]])});
                    m_last = eg[1];
                    m_idle = 1'b0;
                    pushed++;
                end
            end else begin
                chk("sb_ready_busy", 32'(req_ready[0]), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_n[k]     = 1'b0;
            req_valid[k] = 2'b00;
            req_x[k]     = '0;
            req_y[k]     = '0;
            rsp_ready[k] = 1'b1;
        end
        vecs[0] = '{2'b01, 8'hA5, 8'h3C, 8'h00, 8'h00, 2'b01};
        vecs[1] = '{2'b10, 8'h00, 8'h00, 8'h6E, 8'h91, 2'b10};
        vecs[2] = '{2'b11, 8'h01, 8'h02, 8'hF0, 8'h0F, 2'b01};
        vecs[3] = '{2'b11, 8'h01, 8'h02, 8'hF0, 8'h0F, 2'b10};
        vecs[4] = '{2'b11, 8'h01, 8'h02, 8'hF0, 8'h0F, 2'b01};
        vecs[5] = '{2'b11, 8'h01, 8'h02, 8'hF0, 8'h0F, 2'b10};

        repeat (2) cyc();
        for (int k = 0; k < NI; k++) begin
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 0);
            chk("rst_rsp_data", 32'(rsp_data[k]), 0);
            chk("rst_rsp_id", 32'(rsp_id[k]), 0);
            chk("rst_busy", 32'(busy[k]), 0);
            rst_n[k] = 1'b1;
        end
        cyc();

        // Vector table on instance 0 (EXEC_CYCLES=1): single requests then ties.
        for (int i = 0; i < 6; i++) begin
            req_valid[0] = vecs[i].valid;
            req_x[0][0]  = vecs[i].x0;
            req_y[0][0]  = vecs[i].y0;
            req_x[0][1]  = vecs[i].x1;
            req_y[0][1]  = vecs[i].y1;
            run_op(0, vecs[i].exp_rdy,
                   vecs[i].exp_rdy[1] ? golden(vecs[i].x1, vecs[i].y1)
                                      : golden(vecs[i].x0, vecs[i].y0), 1'b0);
        end
        req_valid[0] = 2'b00;
        cyc();

        // Response backpressure with requester 1 held valid.
        rsp_ready[0]   = 1'b0;
        req_valid[0]   = 2'b10;
        req_x[0][1]    = 8'h77;
        req_y[0][1]    = 8'h99;
        #3;
        chk("bp_ready", 32'(req_ready[0]), 32'(2'b10));
        cyc();
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid[0]), 1);
            chk("bp_data", 32'(rsp_data[0]), 32'(golden(8'h77, 8'h99)));
            chk("bp_id", 32'(rsp_id[0]), 1);
            chk("bp_ready_low", 32'(req_ready[0]), 0);
            cyc();
        end
        rsp_ready[0] = 1'b1;
        cyc();
        chk("bp_idle", 32'(busy[0]), 0);
        chk("bp_regrant", 32'(req_ready[0]), 32'(2'b10));
        cyc();
        chk("bp_reaccept", 32'(busy[0]), 1);
        req_valid[0] = 2'b00;
        cyc();
        chk("bp_second_rsp", 32'(rsp_data[0]), 32'(golden(8'h77, 8'h99)));
        cyc();

        // Multicycle window on instance 1 (EXEC_CYCLES=4); operands change after accept.
        req_valid[1] = 2'b01;
        req_x[1][0]  = 8'h12;
        req_y[1][0]  = 8'h34;
        run_op(1, 2'b01, golden(8'h12, 8'h34), 1'b1);
        req_valid[1] = 2'b00;

        // Reset mid-EXEC on instance 2 (EXEC_CYCLES=3).
        req_valid[2] = 2'b10;
        req_x[2][1]  = 8'h5A;
        req_y[2][1]  = 8'hC3;
        run_op(2, 2'b10, golden(8'h5A, 8'hC3), 1'b0);
        req_valid[2] = 2'b01;
        req_x[2][0]  = 8'h33;
        req_y[2][0]  = 8'h44;
        #3;
        chk("rx_ready", 32'(req_ready[2]), 32'(2'b01));
        cyc();
        req_valid[2] = 2'b00;
        cyc();
        #2;
        rst_n[2] = 1'b0;
        #1;
        chk("rx_busy", 32'(busy[2]), 0);
        chk("rx_rsp_valid", 32'(rsp_valid[2]), 0);
        chk("rx_rsp_data", 32'(rsp_data[2]), 0);
        chk("rx_rsp_id", 32'(rsp_id[2]), 0);
        repeat (2) cyc();
        rst_n[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rx_no_rsp", 32'(rsp_valid[2]), 0);
        end
        req_valid[2] = 2'b11;
        req_x[2][0]  = 8'hC8;
        req_y[2][0]  = 8'h2D;
        req_x[2][1]  = 8'h0B;
        req_y[2][1]  = 8'hE7;
        run_op(2, 2'b01, golden(8'hC8, 8'h2D), 1'b0);
        req_valid[2] = 2'b00;

        // Random sweep on instance 0 after a fresh reset.
        rst_n[0] = 1'b0;
        cyc();
        rst_n[0] = 1'b1;
        cyc();
        m_idle = 1'b1;
        m_last = 1'b1;
        sb_en  = 1'b1;
        for (int c = 0; c < 20000 && popped < 256; c++) begin
            req_valid[0] = (pushed < 256) ? 2'($urandom_range(0, 3)) : 2'b00;
            req_x[0]     = 16'($urandom);
            req_y[0]     = 16'($urandom);
            rsp_ready[0] = 1'($urandom_range(0, 1));
            cyc();
        end
        sb_en = 1'b0;
        chk("sb_popped", 32'(popped), 256);
        chk("sb_pushed", 32'(pushed), 256);
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
